// File: rtl/store_buffer_pkg.sv
// Shared types, widths and size decoders for the store buffer.
package store_buffer_pkg;

  localparam int unsigned AddrW            = 32;
  localparam int unsigned DataW            = 32;
  localparam int unsigned TypeW            = 4;
  localparam int unsigned StoreBufferDepth = 8;

  typedef enum logic [TypeW-1:0] {
    TypeLb  = 4'd0,
    TypeLh  = 4'd1,
    TypeLw  = 4'd2,
    TypeLbu = 4'd3,
    TypeLhu = 4'd4,
    TypeSb  = 4'd5,
    TypeSh  = 4'd6,
    TypeSw  = 4'd7
  } inst_type_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } drain_state_e;

  // Bytes written by a store; unknown encodings are treated as a word.
  function automatic logic [2:0] st_size(logic [TypeW-1:0] t);
    case (t)
      TypeSb:  return 3'd1;
      TypeSh:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Bytes read by a load; unknown encodings are treated as a word.
  function automatic logic [2:0] ld_size(logic [TypeW-1:0] t);
    case (t)
      TypeLb, TypeLbu: return 3'd1;
      TypeLh, TypeLhu: return 3'd2;
      default:         return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Commit, memory-drain and load-check bundle of the store buffer.
// STORE_BUFFER_FWD_EN adds the load-forwarding outputs.
interface store_buffer_if import store_buffer_pkg::*; #(
  parameter int unsigned DEPTH = StoreBufferDepth,
  parameter int unsigned PTR_W = $clog2(DEPTH)
);
  logic             commit_en_in;
  logic [AddrW-1:0] commit_addr_in;
  logic [DataW-1:0] commit_data_in;
  logic [TypeW-1:0] commit_type_in;
  logic             full_out;
  logic             empty_out;
  logic [PTR_W:0]   count_out;
  logic             mem_en_out;
  logic [AddrW-1:0] mem_addr_out;
  logic [DataW-1:0] mem_wdata_out;
  logic [TypeW-1:0] mem_type_out;
  logic             mem_finish_in;
  logic             ld_chk_en_in;
  logic [AddrW-1:0] ld_addr_in;
  logic [TypeW-1:0] ld_type_in;
  logic             ld_conflict_out;
`ifdef STORE_BUFFER_FWD_EN
  logic             ld_fwd_hit_out;
  logic [DataW-1:0] ld_fwd_data_out;
`endif

  // Store buffer side.
  modport slave (
`ifdef STORE_BUFFER_FWD_EN
    output ld_fwd_hit_out, ld_fwd_data_out,
`endif
    input  commit_en_in, commit_addr_in, commit_data_in, commit_type_in,
    input  mem_finish_in, ld_chk_en_in, ld_addr_in, ld_type_in,
    output full_out, empty_out, count_out, mem_en_out, mem_addr_out,
    output mem_wdata_out, mem_type_out, ld_conflict_out
  );

  // ROB / RAM controller / load buffer side.
  modport master (
`ifdef STORE_BUFFER_FWD_EN
    input  ld_fwd_hit_out, ld_fwd_data_out,
`endif
    output commit_en_in, commit_addr_in, commit_data_in, commit_type_in,
    output mem_finish_in, ld_chk_en_in, ld_addr_in, ld_type_in,
    input  full_out, empty_out, count_out, mem_en_out, mem_addr_out,
    input  mem_wdata_out, mem_type_out, ld_conflict_out
  );

endinterface

// File: rtl/sb_overlap_chk.sv
// Byte-range overlap / exact-match check between one store entry and a load.
module sb_overlap_chk import store_buffer_pkg::*; (
  input  logic [AddrW-1:0] st_addr_i,
  input  logic [TypeW-1:0] st_type_i,
  input  logic [AddrW-1:0] ld_addr_i,
  input  logic [TypeW-1:0] ld_type_i,
  input  logic             valid_i,
  output logic             overlap_o,
  output logic             exact_o
);

  logic [2:0]     st_sz, ld_sz;
  logic [AddrW:0] st_lo, st_hi, ld_lo, ld_hi;

  // One extra bit keeps end addresses near 2^32 from wrapping.
  always_comb begin
    st_sz     = st_size(st_type_i);
    ld_sz     = ld_size(ld_type_i);
    st_lo     = {1'b0, st_addr_i};
    ld_lo     = {1'b0, ld_addr_i};
    st_hi     = st_lo + {{(AddrW-2){1'b0}}, st_sz};
    ld_hi     = ld_lo + {{(AddrW-2){1'b0}}, ld_sz};
    overlap_o = valid_i && (ld_lo < st_hi) && (st_lo < ld_hi);
    exact_o   = valid_i && (st_addr_i == ld_addr_i) && (st_sz == ld_sz);
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between ROB commit and the byte-serial RAM controller.
// Optional STORE_BUFFER_FWD_EN: forward data to loads exactly matching the youngest store.
module store_buffer import store_buffer_pkg::*; #(
  parameter int unsigned DEPTH = StoreBufferDepth,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy_in,
  input  logic rob_flush_in,
  store_buffer_if.slave sb_if
);

  logic [AddrW-1:0] addr_q [DEPTH];
  logic [DataW-1:0] data_q [DEPTH];
  logic [TypeW-1:0] type_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W:0]   head_q, head_d, tail_q, tail_d;
  drain_state_e     state_q, state_d;

  logic             empty, full, push, pop;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic [DEPTH-1:0] ovl, exact;

  // Committed stores are architectural, so a flush never touches them.
  logic unused_flush;
  assign unused_flush = rob_flush_in;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);

  // Push/pop decode and pointer/valid next state.
  always_comb begin
    push    = rdy_in && sb_if.commit_en_in && !full;
    pop     = rdy_in && sb_if.mem_finish_in && !empty && (state_q == StIssue);
    head_d  = head_q + {{PTR_W{1'b0}}, pop};
    tail_d  = tail_q + {{PTR_W{1'b0}}, push};
    valid_d = valid_q;
    if (push) valid_d[tail_idx] = 1'b1;
    if (pop)  valid_d[head_idx] = 1'b0;
  end

  // Drain FSM: enter ISSUE as soon as the buffer will hold an entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (head_d != tail_d) state_d = StIssue;
      StIssue: if (head_d == tail_d) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pointer, valid and FSM state; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      state_q <= StIdle;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  // Entry payload; contents are only observed through valid_q / empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      addr_q[tail_idx] <= sb_if.commit_addr_in;
      data_q[tail_idx] <= sb_if.commit_data_in;
      type_q[tail_idx] <= sb_if.commit_type_in;
    end
  end

  assign sb_if.full_out      = full;
  assign sb_if.empty_out     = empty;
  assign sb_if.count_out     = tail_q - head_q;
  // Dropped during the finish cycle so the idle controller cannot restart the old store.
  assign sb_if.mem_en_out    = (state_q == StIssue) && !empty && !sb_if.mem_finish_in;
  assign sb_if.mem_addr_out  = empty ? '0 : addr_q[head_idx];
  assign sb_if.mem_wdata_out = empty ? '0 : data_q[head_idx];
  assign sb_if.mem_type_out  = empty ? '0 : type_q[head_idx];

  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    sb_overlap_chk u_chk (
      .st_addr_i (addr_q[i]),
      .st_type_i (type_q[i]),
      .ld_addr_i (sb_if.ld_addr_in),
      .ld_type_i (sb_if.ld_type_in),
      .valid_i   (valid_q[i]),
      .overlap_o (ovl[i]),
      .exact_o   (exact[i])
    );
  end

`ifdef STORE_BUFFER_FWD_EN
  logic             fwd_found, fwd_hit;
  logic [PTR_W-1:0] fwd_idx, scan_idx;
  logic [DataW-1:0] fwd_raw, fwd_ext;

  // Walk oldest to youngest so the last overlapping entry wins.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + i[PTR_W-1:0];
      if (ovl[scan_idx]) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
    fwd_hit = sb_if.ld_chk_en_in && fwd_found && exact[fwd_idx];
  end

  // Extend the forwarded store data to the load's width and signedness.
  always_comb begin
    fwd_raw = data_q[fwd_idx];
    case (sb_if.ld_type_in)
      TypeLb:  fwd_ext = {{(DataW-8){fwd_raw[7]}}, fwd_raw[7:0]};
      TypeLbu: fwd_ext = {{(DataW-8){1'b0}}, fwd_raw[7:0]};
      TypeLh:  fwd_ext = {{(DataW-16){fwd_raw[15]}}, fwd_raw[15:0]};
      TypeLhu: fwd_ext = {{(DataW-16){1'b0}}, fwd_raw[15:0]};
      default: fwd_ext = fwd_raw;
    endcase
  end

  assign sb_if.ld_fwd_hit_out  = fwd_hit;
  assign sb_if.ld_fwd_data_out = fwd_hit ? fwd_ext : '0;
  assign sb_if.ld_conflict_out = sb_if.ld_chk_en_in && (|ovl) && !fwd_hit;
`else
  logic unused_exact;
  assign unused_exact          = ^exact;
  assign sb_if.ld_conflict_out = sb_if.ld_chk_en_in && (|ovl);
`endif

endmodule
